// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: round-robin four-phase intersection controller with
// green/yellow/all-red/walk interval timing and emergency-vehicle preemption.
module intersection_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_str_sensor,
    input  logic       ew_left_sensor,
    input  logic       ns_sensor,
    input  logic       ped_button,
    input  logic       emerg,
    input  logic [1:0] emerg_dir,
    output logic [1:0] ew_str_light,
    output logic [1:0] ew_left_light,
    output logic [1:0] ns_light,
    output logic       walk,
    output logic [1:0] phase,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALLRED, WALK, PREEMPT} state_t;

    localparam logic [7:0] G_MIN = 8'(GREEN_MIN);
    localparam logic [7:0] G_MAX = 8'(GREEN_MAX);
    localparam logic [7:0] Y_T   = 8'(YELLOW_T);
    localparam logic [7:0] A_T   = 8'(ALLRED_T);
    localparam logic [7:0] W_T   = 8'(WALK_T);

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [1:0] last_q, last_d;
    logic [3:0] pend_q, pend_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] ins, req, own, served, enter;
    logic [1:0] win, idx;
    logic       found, arb, go, lit, yel;

    assign ins = {ped_button, ns_sensor, ew_left_sensor, ew_str_sensor};
    assign req = pend_q | ins;
    assign own = 4'b0001 << phase_q;

    // Round-robin search begins just after the most recently served phase.
    always_comb begin
        win = last_q;
        idx = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        arb     = 1'b0;
        case (state_q)
            IDLE: arb = 1'b1;
            GREEN: begin
                if (emerg && emerg_dir == phase_q) begin
                    cnt_d = cnt_q;
                end else if (emerg || (cnt_q >= G_MIN && !ins[phase_q]) ||
                             (cnt_q >= G_MAX && |(req & ~own))) begin
                    state_d = YELLOW;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = (cnt_q >= G_MAX) ? cnt_q : cnt_q + 8'd1;
                end
            end
            YELLOW: begin
                state_d = (cnt_q >= Y_T) ? ALLRED : YELLOW;
                cnt_d   = (cnt_q >= Y_T) ? 8'd1 : cnt_q + 8'd1;
            end
            WALK: begin
                state_d = (emerg || cnt_q >= W_T) ? ALLRED : WALK;
                cnt_d   = (emerg || cnt_q >= W_T) ? 8'd1 : cnt_q + 8'd1;
            end
            ALLRED: begin
                arb   = cnt_q >= A_T;
                cnt_d = cnt_q + 8'd1;
            end
            PREEMPT: begin
                // An all-red hold has no yellow to show on release.
                state_d = emerg ? PREEMPT : (phase_q == 2'd3) ? ALLRED : YELLOW;
                cnt_d   = 8'd1;
            end
            default: state_d = IDLE;
        endcase
        if (arb) begin
            state_d = emerg ? PREEMPT : !(|req) ? IDLE : (win == 2'd3) ? WALK : GREEN;
            phase_d = emerg ? emerg_dir : (|req) ? win : phase_q;
            last_d  = (!emerg && |req) ? win : last_q;
            cnt_d   = 8'd1;
        end
    end

    assign go     = arb & (emerg | (|req));
    assign served = (state_q == GREEN || state_q == WALK ||
                     (state_q == PREEMPT && phase_q != 2'd3)) ? own : 4'b0000;
    assign enter  = go ? (4'b0001 << phase_d) : 4'b0000;
    assign pend_d = (pend_q | (ins & ~served)) & ~enter;

    assign lit = state_d == GREEN || (state_d == PREEMPT && phase_d != 2'd3);
    assign yel = state_d == YELLOW;

    function automatic logic [1:0] lamp(input logic [1:0] p, input logic [1:0] ph,
                                        input logic g, input logic y);
        return (p != ph) ? 2'b00 : g ? 2'b10 : y ? 2'b01 : 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            phase_q       <= 2'd0;
            last_q        <= 2'd3;
            pend_q        <= 4'b0000;
            cnt_q         <= 8'd0;
            ew_str_light  <= 2'b00;
            ew_left_light <= 2'b00;
            ns_light      <= 2'b00;
            walk          <= 1'b0;
            phase         <= 2'd0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            last_q        <= last_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
            ew_str_light  <= lamp(2'd0, phase_d, lit, yel);
            ew_left_light <= lamp(2'd1, phase_d, lit, yel);
            ns_light      <= lamp(2'd2, phase_d, lit, yel);
            walk          <= state_d == WALK;
            phase         <= (state_d == IDLE) ? 2'd0 : phase_d;
            busy          <= state_d != IDLE;
        end
    end
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: directed test-plan scenarios with literal expectations,
// then randomized traffic, all checked every cycle against an interval-level model.
module tb_intersection_phase_scheduler;
    localparam int GMIN = 4, GMAX = 10, YT = 2, ART = 1, WT = 6;
    localparam int MI = 0, MG = 1, MY = 2, MR = 3, MW = 4, MH = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ew_str_sensor = 1'b0, ew_left_sensor = 1'b0, ns_sensor = 1'b0, ped_button = 1'b0;
    logic emerg = 1'b0;
    logic [1:0] emerg_dir = 2'd0;
    logic [1:0] ew_str_light, ew_left_light, ns_light, phase;
    logic walk, busy;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;
    int m_mode, m_ph, m_t, m_left, m_last;
    bit m_pend[4];
    int exp_l[3];
    int exp_walk, exp_phase, exp_busy;
    int r_s[64], r_l[64], r_n[64], r_w[64], r_b[64];
    int g;

    intersection_phase_scheduler dut (
        .clk(clk), .reset(reset),
        .ew_str_sensor(ew_str_sensor), .ew_left_sensor(ew_left_sensor),
        .ns_sensor(ns_sensor), .ped_button(ped_button),
        .emerg(emerg), .emerg_dir(emerg_dir),
        .ew_str_light(ew_str_light), .ew_left_light(ew_left_light), .ns_light(ns_light),
        .walk(walk), .phase(phase), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", n, a, e, $time);
        end
    endfunction

    // The model tracks which interval is showing and how long it has left to run.
    task automatic model_step();
        int s[4];
        bit r[4];
        bit other, arb;
        int srv, nm, np, win;
        s[0] = int'(ew_str_sensor);
        s[1] = int'(ew_left_sensor);
        s[2] = int'(ns_sensor);
        s[3] = int'(ped_button);
        if (!reset) begin
            m_mode = MI; m_ph = 0; m_t = 0; m_left = 0; m_last = 3;
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) r[i] = m_pend[i] || s[i] != 0;
            srv = (m_mode == MG || m_mode == MW || (m_mode == MH && m_ph != 3)) ? m_ph : -1;
            for (int i = 0; i < 4; i++) if (s[i] != 0 && i != srv) m_pend[i] = 1'b1;
            arb = 1'b0; nm = m_mode; np = m_ph;
            case (m_mode)
                MI: arb = 1'b1;
                MG: begin
                    other = 1'b0;
                    for (int i = 0; i < 4; i++) if (i != m_ph && r[i]) other = 1'b1;
                    if (emerg && int'(emerg_dir) == m_ph) begin
                        m_t = m_t;
                    end else if (emerg || (m_t >= GMIN && s[m_ph] == 0) || (m_t >= GMAX && other)) begin
                        nm = MY; m_left = YT;
                    end else if (m_t < GMAX) m_t++;
                end
                MY: if (m_left > 1) m_left--; else begin nm = MR; m_left = ART; end
                MW: if (emerg || m_left == 1) begin nm = MR; m_left = ART; end else m_left--;
                MR: if (m_left > 1) m_left--; else arb = 1'b1;
                MH: if (!emerg) begin nm = (m_ph == 3) ? MR : MY; m_left = (m_ph == 3) ? ART : YT; end
                default: nm = MI;
            endcase
            if (arb) begin
                win = -1;
                for (int k = 1; k <= 4; k++) if (win < 0 && r[(m_last + k) % 4]) win = (m_last + k) % 4;
                if (emerg) begin
                    nm = MH; np = int'(emerg_dir); m_pend[np] = 1'b0;
                end else if (win < 0) begin
                    nm = MI;
                end else begin
                    np = win; m_last = win; m_pend[win] = 1'b0;
                    nm = (win == 3) ? MW : MG; m_t = 1; m_left = WT;
                end
            end
            m_mode = nm; m_ph = np;
        end
        for (int i = 0; i < 3; i++) exp_l[i] = 0;
        if (m_mode == MG || (m_mode == MH && m_ph < 3)) exp_l[m_ph] = 2;
        if (m_mode == MY) exp_l[m_ph] = 1;
        exp_walk  = (m_mode == MW) ? 1 : 0;
        exp_busy  = (m_mode != MI) ? 1 : 0;
        exp_phase = (m_mode == MI) ? 0 : m_ph;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ew_str_light", int'(ew_str_light), exp_l[0]);
            chk("ew_left_light", int'(ew_left_light), exp_l[1]);
            chk("ns_light", int'(ns_light), exp_l[2]);
            chk("walk", int'(walk), exp_walk);
            chk("phase", int'(phase), exp_phase);
            chk("busy", int'(busy), exp_busy);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic step(input int i);
        cyc();
        r_s[i] = int'(ew_str_light);
        r_l[i] = int'(ew_left_light);
        r_n[i] = int'(ns_light);
        r_w[i] = int'(walk);
        r_b[i] = int'(busy);
    endtask

    task automatic setin(input bit a, input bit b, input bit c, input bit d, input bit e, input int ed);
        ew_str_sensor = a; ew_left_sensor = b; ns_sensor = c; ped_button = d;
        emerg = e; emerg_dir = 2'(ed);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        int t1_l[8];
        int t1_b[8];
        t1_l = '{2, 2, 2, 2, 1, 1, 0, 0};
        t1_b = '{1, 1, 1, 1, 1, 1, 1, 0};
        setin(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_busy", int'(busy), 0);
        chk("rst_lights", int'({ew_str_light, ew_left_light, ns_light, walk}), 0);
        chk("rst_phase", int'(phase), 0);

        reset = 1'b1;
        ew_left_sensor = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 2) ew_left_sensor = 1'b0;
            chk("t1_left_seq", int'(ew_left_light), t1_l[i]);
            chk("t1_busy_seq", int'(busy), t1_b[i]);
        end
        repeat (3) cyc();
        chk("t1_pending_empty", int'(busy), 0);

        ns_sensor = 1'b1;
        g = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            g += (ns_light == 2'b10) ? 1 : 0;
        end
        chk("t2_ns_rest_green_cycles", g, 30);
        ns_sensor = 1'b0;
        repeat (8) cyc();
        ns_sensor = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(i);
            if (i == 3) ew_str_sensor = 1'b1;
        end
        chk("t2_ns_green_c10", r_n[10], 2);
        chk("t2_ns_yellow_c11", r_n[11], 1);
        chk("t2_ns_yellow_c12", r_n[12], 1);
        chk("t2_allred_c13", r_n[13] + r_s[13], 0);
        chk("t2_str_green_c14", r_s[14], 2);
        setin(0, 0, 0, 0, 0, 0);
        repeat (40) cyc();

        do_reset();
        setin(1, 1, 1, 1, 0, 0);
        for (int i = 1; i <= 47; i++) step(i);
        chk("t3_str_c1", r_s[1], 2);
        chk("t3_str_c10", r_s[10], 2);
        chk("t3_str_yel_c11", r_s[11], 1);
        chk("t3_left_c14", r_l[14], 2);
        chk("t3_left_c23", r_l[23], 2);
        chk("t3_ns_c27", r_n[27], 2);
        chk("t3_walk_c40", r_w[40], 1);
        chk("t3_walk_c45", r_w[45], 1);
        chk("t3_walk_end_c46", r_w[46] + r_s[46], 0);
        chk("t3_str_again_c47", r_s[47], 2);
        setin(0, 0, 0, 0, 0, 0);

        do_reset();
        setin(1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 14; i++) begin
            step(i);
            if (i == 2) begin emerg = 1'b1; emerg_dir = 2'd2; end
            if (i == 10) emerg = 1'b0;
        end
        chk("t4_str_c2", r_s[2], 2);
        chk("t4_str_yel_c3", r_s[3], 1);
        chk("t4_str_yel_c4", r_s[4], 1);
        chk("t4_allred_c5", r_s[5] + r_n[5], 0);
        chk("t4_ns_pre_c6", r_n[6], 2);
        chk("t4_ns_pre_c10", r_n[10], 2);
        chk("t4_ns_yel_c11", r_n[11], 1);
        chk("t4_allred_c13", r_n[13] + r_l[13], 0);
        chk("t4_left_c14", r_l[14], 2);
        setin(0, 0, 0, 0, 0, 0);

        do_reset();
        ped_button = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(i);
            if (i == 1) ped_button = 1'b0;
            if (i == 3) begin emerg = 1'b1; emerg_dir = 2'd3; end
            if (i == 10) emerg = 1'b0;
        end
        chk("t5_walk_c3", r_w[3], 1);
        chk("t5_walk_cut_c4", r_w[4], 0);
        chk("t5_busy_c8", r_b[8], 1);
        chk("t5_hold_red_c8", r_s[8] + r_l[8] + r_n[8], 0);
        chk("t5_idle_c12", r_b[12], 0);

        do_reset();
        setin(1, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(i);
            if (i == 1) setin(0, 0, 0, 0, 0, 0);
        end
        chk("t6_yellow_c5", r_s[5], 1);
        reset = 1'b0;
        cyc();
        chk("t6_reset_busy", int'(busy), 0);
        chk("t6_reset_light", int'(ew_str_light), 0);
        reset = 1'b1;
        repeat (3) cyc();
        chk("t6_ped_lost", int'(busy), 0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) ew_str_sensor = ~ew_str_sensor;
            if ($urandom_range(0, 7) == 0) ew_left_sensor = ~ew_left_sensor;
            if ($urandom_range(0, 7) == 0) ns_sensor = ~ns_sensor;
            ped_button = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) begin
                emerg = ~emerg;
                emerg_dir = 2'($urandom_range(0, 3));
            end else if (emerg && $urandom_range(0, 29) == 0) begin
                emerg_dir = 2'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 399) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
